// File: rtl/led_pattern_module_if.sv
// Configuration bus for the LED pattern generator: per-channel window/mode
// writes and period writes. The board controller drives (master), the
// pattern generator samples (slave). The port is always ready.
interface led_pattern_module_if #(
   parameter int CH_W  = 2,
   parameter int CNT_W = 24
) ();
   logic             Cfg_Wr;
   logic [CH_W-1:0]  Cfg_Ch;
   logic [1:0]       Cfg_Mode;
   logic [CNT_W-1:0] Cfg_Start;
   logic [CNT_W-1:0] Cfg_End;
   logic             Period_Wr;
   logic [CNT_W-1:0] Period_In;

   modport master (
      output Cfg_Wr, Cfg_Ch, Cfg_Mode, Cfg_Start, Cfg_End, Period_Wr, Period_In
   );

   modport slave (
      input Cfg_Wr, Cfg_Ch, Cfg_Mode, Cfg_Start, Cfg_End, Period_Wr, Period_In
   );
endinterface

// File: rtl/led_pattern_module.sv
// Multi-channel LED pattern generator. One shared period counter drives all
// channels; each channel compares the counter against its own window and
// applies its mode. Configuration lands in a pending set and is copied to
// the active set only on the wrap cycle, so a pattern never changes
// mid-period.
module led_pattern_module #(
   parameter int               CHANNELS = 4,
   parameter int               CH_W     = 2,
   parameter int               CNT_W    = 24,
   parameter logic [CNT_W-1:0] PERIOD   = 24'd16_000_000,
   parameter logic [CNT_W-1:0] ON_START = 24'd8_000_000,
   parameter logic [CNT_W-1:0] ON_END   = 24'd15_500_000
) (
   input  logic                CLK,
   input  logic                RSTn,
   led_pattern_module_if.slave cfg,
   output logic [CHANNELS-1:0] LED_Out,
   output logic                Period_Tick
);

   typedef enum logic [1:0] {
      MODE_OFF = 2'd0,
      MODE_ON  = 2'd1,
      MODE_WIN = 2'd2,
      MODE_INV = 2'd3
   } mode_t;

   // Shared counter and period registers
   logic [CNT_W-1:0]    count_r;
   logic [CNT_W-1:0]    count_next_s;
   logic                wrap_s;
   logic [CNT_W-1:0]    pend_period_r;
   logic [CNT_W-1:0]    act_period_r;

   // Per-channel pending and active configuration
   mode_t               pend_mode_r  [CHANNELS];
   logic [CNT_W-1:0]    pend_start_r [CHANNELS];
   logic [CNT_W-1:0]    pend_end_r   [CHANNELS];
   mode_t               act_mode_r   [CHANNELS];
   logic [CNT_W-1:0]    act_start_r  [CHANNELS];
   logic [CNT_W-1:0]    act_end_r    [CHANNELS];

   // Output stage
   logic [CHANNELS-1:0] in_win_s;
   logic [CHANNELS-1:0] led_next_s;
   logic [CHANNELS-1:0] led_r;
   logic                tick_r;

   // Wrap detection and next counter value; >= lets a lowered period wrap at once
   always_comb begin
      wrap_s       = 1'b0;
      count_next_s = count_r;
      if (count_r >= act_period_r) begin
         wrap_s       = 1'b1;
         count_next_s = {CNT_W{1'b0}};
      end else begin
         wrap_s       = 1'b0;
         count_next_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Per-channel window test and mode selection on the current count
   always_comb begin
      in_win_s   = {CHANNELS{1'b0}};
      led_next_s = {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
         in_win_s[i] = (count_r >= act_start_r[i]) && (count_r < act_end_r[i]);
         case (act_mode_r[i])
            MODE_OFF: led_next_s[i] = 1'b0;
            MODE_ON:  led_next_s[i] = 1'b1;
            MODE_WIN: led_next_s[i] = in_win_s[i];
            MODE_INV: led_next_s[i] = ~in_win_s[i];
            default:  led_next_s[i] = 1'b0;
         endcase
      end
   end

   // Counter, registered LED drive and wrap pulse
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         count_r <= {CNT_W{1'b0}};
         led_r   <= {CHANNELS{1'b0}};
         tick_r  <= 1'b0;
      end else begin
         count_r <= count_next_s;
         led_r   <= led_next_s;
         tick_r  <= wrap_s;
      end
   end

   // Period double buffer: commit reads the pending value from before this edge's write
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         pend_period_r <= PERIOD;
         act_period_r  <= PERIOD;
      end else begin
         if (wrap_s) begin
            act_period_r <= pend_period_r;
         end
         if (cfg.Period_Wr) begin
            pend_period_r <= cfg.Period_In;
         end
      end
   end

   // Channel double buffer: out-of-range channel indices match no entry and are dropped
   always_ff @(posedge CLK) begin
      for (int i = 0; i < CHANNELS; i++) begin
         if (!RSTn) begin
            pend_mode_r[i]  <= MODE_WIN;
            pend_start_r[i] <= ON_START;
            pend_end_r[i]   <= ON_END;
            act_mode_r[i]   <= MODE_WIN;
            act_start_r[i]  <= ON_START;
            act_end_r[i]    <= ON_END;
         end else begin
            if (wrap_s) begin
               act_mode_r[i]  <= pend_mode_r[i];
               act_start_r[i] <= pend_start_r[i];
               act_end_r[i]   <= pend_end_r[i];
            end
            if (cfg.Cfg_Wr && (cfg.Cfg_Ch == CH_W'(i))) begin
               pend_mode_r[i]  <= mode_t'(cfg.Cfg_Mode);
               pend_start_r[i] <= cfg.Cfg_Start;
               pend_end_r[i]   <= cfg.Cfg_End;
            end
         end
      end
   end

   assign LED_Out     = led_r;
   assign Period_Tick = tick_r;

endmodule

// File: tb/tb_led_pattern_module.sv
// Directed bench for led_pattern_module with CNT_W=8, PERIOD=9, ON_START=3,
// ON_END=7, CHANNELS=4. CH_W=3 so that channel index 4 can be presented.
// Timeline: e counts rising edges since reset release; outputs are sampled
// 1 time unit after each edge. After edge e the LEDs show the function of
// the count that was present before that edge.
module tb_led_pattern_module;
   localparam int CHANNELS = 4;
   localparam int CH_W     = 3;
   localparam int CNT_W    = 8;

   logic                CLK = 1'b0;
   logic                RSTn = 1'b0;
   logic [CHANNELS-1:0] LED_Out;
   logic                Period_Tick;

   int n_chk  = 0;
   int n_pass = 0;
   int e      = 0;
   int c      = 0;
   logic w2, w3;

   led_pattern_module_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg ();

   led_pattern_module #(
      .CHANNELS(CHANNELS), .CH_W(CH_W), .CNT_W(CNT_W),
      .PERIOD(8'd9), .ON_START(8'd3), .ON_END(8'd7)
   ) dut (
      .CLK(CLK), .RSTn(RSTn), .cfg(cfg),
      .LED_Out(LED_Out), .Period_Tick(Period_Tick)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge CLK);
      #1;
      e++;
   endtask

   task automatic chk_led(input string tag, input logic [3:0] exp);
      n_chk++;
      assert (LED_Out === exp) n_pass++;
      else $error("FAIL %s e=%0d LED_Out=%b expected=%b", tag, e, LED_Out, exp);
   endtask

   task automatic chk_tick(input string tag, input logic exp);
      n_chk++;
      assert (Period_Tick === exp) n_pass++;
      else $error("FAIL %s e=%0d Period_Tick=%b expected=%b", tag, e, Period_Tick, exp);
   endtask

   task automatic idle();
      cfg.Cfg_Wr    = 1'b0;
      cfg.Cfg_Ch    = 3'd0;
      cfg.Cfg_Mode  = 2'd0;
      cfg.Cfg_Start = 8'd0;
      cfg.Cfg_End   = 8'd0;
      cfg.Period_Wr = 1'b0;
      cfg.Period_In = 8'd0;
   endtask

   task automatic wr_cfg(input int ch, input int mode, input int s, input int en);
      cfg.Cfg_Wr    = 1'b1;
      cfg.Cfg_Ch    = 3'(ch);
      cfg.Cfg_Mode  = 2'(mode);
      cfg.Cfg_Start = 8'(s);
      cfg.Cfg_End   = 8'(en);
   endtask

   task automatic wr_per(input int p);
      cfg.Period_Wr = 1'b1;
      cfg.Period_In = 8'(p);
   endtask

   // Default pattern: high after edges e with e%10 in 4..7 (count 3..6 lagged)
   function automatic logic [3:0] dflt(input int ee);
      return ((ee % 10) >= 4 && (ee % 10) <= 7) ? 4'hF : 4'h0;
   endfunction

   initial begin
      idle();
      RSTn = 1'b0;
      // Outputs held low during reset
      for (int i = 0; i < 3; i++) begin
         step();
         chk_led("rst_led", 4'h0);
         chk_tick("rst_tick", 1'b0);
      end
      RSTn = 1'b1;
      e = 0;

      // Reset defaults over three periods
      for (int k = 0; k < 30; k++) begin
         step();
         chk_led("dflt_led", dflt(e));
         chk_tick("dflt_tick", (e % 10) == 0);
      end

      // Mode writes mid-period: no change before the wrap at e=40
      step();
      step();
      wr_cfg(0, 0, 3, 7);
      step(); chk_led("pre_wrap_led", dflt(e));
      wr_cfg(1, 1, 3, 7);
      step(); chk_led("pre_wrap_led", dflt(e));
      wr_cfg(3, 3, 3, 7);
      step(); chk_led("pre_wrap_led", dflt(e));
      idle();
      for (int k = 0; k < 5; k++) begin
         step();
         chk_led("pre_wrap_led", dflt(e));
         chk_tick("pre_wrap_tick", (e % 10) == 0);
      end

      // New modes from e=41; ch2 rewritten in the wrap cycle (count 9) at edge 50
      for (int k = 0; k < 30; k++) begin
         step();
         c  = (e - 1) % 10;
         w3 = (c >= 3 && c <= 6);
         w2 = (e <= 60) ? w3 : (c < 2);
         chk_led("mode_led", {~w3, w2, 1'b1, 1'b0});
         chk_tick("mode_tick", (e % 10) == 0);
         if (e == 49) wr_cfg(2, 2, 0, 2);
         else if (e == 50) idle();
      end

      // Period 4 and ch2 window 3..7 written together at count 2;
      // period of 10 completes at e=80, then 5-cycle periods.
      // Edge cases written at counts 0..3 of the period ending at e=100.
      for (int k = 0; k < 30; k++) begin
         step();
         if (e <= 80) begin
            c = (e - 1) % 10;
            chk_led("per_old_led", {~(c >= 3 && c <= 6), (c < 2), 1'b1, 1'b0});
            chk_tick("per_old_tick", e == 80);
         end else begin
            c = (e - 81) % 5;
            chk_led("per_new_led", {(c < 3), (c >= 3), 1'b1, 1'b0});
            chk_tick("per_new_tick", ((e - 80) % 5) == 0);
         end
         if (e == 72) begin
            wr_per(4);
            wr_cfg(2, 2, 3, 7);
         end else if (e == 73) idle();
         else if (e == 95) wr_cfg(2, 2, 5, 5);
         else if (e == 96) wr_cfg(1, 1, 0, 0);
         else if (e == 97) wr_cfg(1, 0, 0, 0);
         else if (e == 98) wr_cfg(4, 1, 0, 0);
         else if (e == 99) idle();
      end

      // Empty window, last-write-wins, ignored channel 4; then P=0
      for (int k = 0; k < 27; k++) begin
         step();
         if (e <= 115) begin
            c = (e - 101) % 5;
            chk_led("edge_led", {(c < 3), 3'b000});
            chk_tick("edge_tick", ((e - 100) % 5) == 0);
         end else if (e <= 126) begin
            chk_led("p0_led", 4'b1000);
            chk_tick("p0_tick", 1'b1);
         end else begin
            chk_led("p0_commit_led", 4'b1001);
            chk_tick("p0_tick", 1'b1);
         end
         if (e == 110) wr_per(0);
         else if (e == 111) idle();
         else if (e == 124) wr_cfg(0, 1, 0, 0);
         else if (e == 125) idle();
      end

      // Pending writes discarded by a one-cycle reset
      wr_cfg(1, 1, 0, 0);
      wr_per(2);
      step();
      chk_led("pre_rst_led", 4'b1001);
      idle();
      RSTn = 1'b0;
      step();
      chk_led("mid_rst_led", 4'h0);
      chk_tick("mid_rst_tick", 1'b0);
      RSTn = 1'b1;
      e = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         chk_led("post_rst_led", dflt(e));
         chk_tick("post_rst_tick", (e % 10) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/led_pattern_module.md
# led_pattern_module

Multi-channel, runtime-configurable LED pattern generator that drives a bank of LED pins from one shared period counter. Each channel has its own on-window and mode, written over a simple configuration port. New settings are double-buffered and take effect only at a period boundary, so patterns never glitch mid-period. It sits between the board-level control logic and the LED pins, and replaces single-pattern, fixed-constant blinker blocks.

## Interface
- CHANNELS, 4: number of LED outputs, ≥1.
- CH_W, 2: width of Cfg_Ch; must satisfy 2^CH_W ≥ CHANNELS.
- CNT_W, 24: width of the period counter and of the window bounds.
- PERIOD, 24'd16_000_000: reset value of the period register P.
- ON_START, 24'd8_000_000: reset value of every channel's window start.
- ON_END, 24'd15_500_000: reset value of every channel's window end.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RSTn  in  1  synchronous, active-low reset, sampled on the rising edge of CLK.
- Cfg_Wr  in  1  one-cycle write strobe for channel configuration.
- Cfg_Ch  in  CH_W  channel index for the write.
- Cfg_Mode  in  2  channel mode: 0 = off, 1 = on, 2 = window, 3 = inverted window.
- Cfg_Start  in  CNT_W  window start, inclusive.
- Cfg_End  in  CNT_W  window end, exclusive.
- Period_Wr  in  1  write strobe for the period register.
- Period_In  in  CNT_W  new value of P.
- LED_Out  out  CHANNELS  registered LED drive; bit i belongs to channel i.
- Period_Tick  out  1  registered one-cycle pulse for each counter wrap.

## Operation
- Register sets:
  - Pending set: per-channel mode/start/end plus a pending P. Written by Cfg_Wr and Period_Wr.
  - Active set: used to generate the outputs.
- Counter Count (CNT_W bits):
  - Increments by 1 each cycle.
  - When Count ≥ active P (the wrap cycle), the next value is 0. The period is therefore P+1 cycles.
  - Using ≥ rather than = means a lowered P takes effect cleanly.
- Commit: on the wrap cycle edge, the entire pending set is copied into the active set. Evaluation at Count = 0 uses the new values.
- Per-channel output function, evaluated on the current Count:
  - in_win = (Count ≥ start) && (Count < end).
  - Mode 0 → 0.
  - Mode 1 → 1.
  - Mode 2 → in_win.
  - Mode 3 → !in_win.
- Configuration writes:
  - Cfg_Wr with Cfg_Ch ≥ CHANNELS is ignored.
  - Multiple writes to the same pending entry within one period: the last one wins.
  - Cfg_Wr and Period_Wr may be asserted in the same cycle; both take effect.
- Window edge cases:
  - start ≥ end: in_win is never true (mode 2 is constantly 0, mode 3 constantly 1).
  - end > P: the window is clipped at the wrap.
- P = 0: Count stays at 0, every cycle is a wrap cycle, and a commit happens every cycle.
- No handshake back-pressure: the configuration port is always ready.

## Timing
- Reset (RSTn = 0 at an edge):
  - Count = 0, LED_Out = 0, Period_Tick = 0.
  - Pending and active sets are loaded with P = PERIOD and start/end = ON_START/ON_END on all channels. Mode = 2 on all channels.
  - A reset asserted mid-period discards any pending writes.
- Output latency: LED_Out[i] reflects the Count value from one cycle earlier (one register stage).
  - With the default window, LED_Out goes high on the edge after Count = ON_START is evaluated, and low on the edge after Count = ON_END is evaluated.
- Period_Tick: high for exactly the one cycle that follows each wrap cycle, i.e. aligned with Count = 0 being present.
- Write latency:
  - A write made in any cycle before a wrap cycle is committed at that wrap. It affects LED_Out from the first cycle after Count = 0 is registered.
  - A write made in the wrap cycle itself lands in the pending set on the same edge as the commit. It is not committed until the following wrap.
- First cycle after reset release: Count = 0 is evaluated with the reset defaults.

## Test plan
Bench parameters: CNT_W = 8, PERIOD = 9, ON_START = 3, ON_END = 7, CHANNELS = 4.

1. Reset defaults: release RSTn and run 30 cycles → every LED_Out bit is high for Count 3–6 (lagged one cycle) and low otherwise. Period_Tick pulses every 10 cycles. All outputs are 0 while RSTn = 0.
2. Modes: write ch0 mode 0, ch1 mode 1, ch3 mode 3 (start 3, end 7) mid-period → no output change until the wrap. After the wrap: bit0 = 0, bit1 = 1, bit3 is low exactly where bit2 is high.
3. Shadow timing: write ch2 start 0, end 2 in the wrap cycle (Count = 9) → the old window is used for the next full period and the new window from the period after.
4. Period change: Period_Wr with 4 mid-period → the current period completes with 10 cycles, later periods have 5 cycles. A window with end 7 stays high from Count 3 through the wrap.
5. Edge cases: P = 0 → Period_Tick is constantly 1. Start 5, end 5 in mode 2 → always 0. Cfg_Ch = 4 is ignored. Two writes to ch1 in one period → the second one is applied.
6. Mid-operation reset: make pending writes, then assert RSTn for one cycle → all registers return to their defaults and the pending writes are never applied.
